// File: rtl/vga_pkg.sv
// Shared timing defaults, frame-size helpers and pipeline
// types for the framebuffer video engine.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 33;
    localparam int DEF_PIX_W = 3;
    localparam int DEF_FB_XW = 8;
    localparam int DEF_FB_H = 240;
    localparam int DEF_SCALE_SHIFT = 1;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    // Counter-derived flags carried one stage alongside the RAM read.
    typedef struct packed {
        logic valid;
        logic active;
        logic in_win;
        logic hs;
        logic vs;
        logic fs;
    } pipe_t;

    function automatic int h_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus raw active and sync flags, all
// combinational from the current counter state.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          video_on_int,
    output logic          hsync_int,
    output logic          vsync_int
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign video_on_int = (32'(h_cnt) < H_ACTIVE)
                       && (32'(v_cnt) < V_ACTIVE);
    assign hsync_int = (32'(h_cnt) >= HS_BEG)
                    && (32'(h_cnt) < HS_END);
    assign vsync_int = (32'(v_cnt) >= VS_BEG)
                    && (32'(v_cnt) < VS_END);

endmodule

// File: rtl/vga_fb_engine.sv
// Framebuffer video engine: timing, scaled RAM read-out and
// a two-stage output pipeline with an independent write port.
module vga_fb_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter int PIX_W = DEF_PIX_W,
    parameter int FB_XW = DEF_FB_XW,
    parameter int FB_H = DEF_FB_H,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int BORDER = 0,
    parameter int SYNC_POL = 0,
    parameter int WR_BLANK_ONLY = 0,
    localparam int FB_YW = $clog2(FB_H)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_XW-1:0] wr_x,
    input  logic [FB_YW-1:0] wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_err,
    output logic [PIX_W-1:0] rgb,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic             frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int FB_W = 2 ** FB_XW;
    localparam int AW = FB_XW + FB_YW;
    localparam int DEPTH = FB_H * FB_W;
    localparam logic SP = (SYNC_POL != 0);
    localparam logic WBO = (WR_BLANK_ONLY != 0);
    localparam logic [PIX_W-1:0] BORDER_PIX = PIX_W'(BORDER);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          video_on_int;
    logic          hsync_int;
    logic          vsync_int;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock        (clock),
        .reset        (reset),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .video_on_int (video_on_int),
        .hsync_int    (hsync_int),
        .vsync_int    (vsync_int)
    );

    logic             in_win;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wr_addr;
    logic             wr_fire;
    logic             wr_in_range;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] fb_mem [DEPTH];
    pipe_t            p1;

    assign in_win = ((32'(h_cnt) >> SCALE_SHIFT) < FB_W)
                 && ((32'(v_cnt) >> SCALE_SHIFT) < FB_H);
    assign rd_addr = {FB_YW'(v_cnt >> SCALE_SHIFT),
                      FB_XW'(h_cnt >> SCALE_SHIFT)};

    assign wr_ready = ~reset & (~WBO | ~video_on_int);
    assign wr_fire = wr_valid & wr_ready;
    assign wr_in_range = 32'(wr_y) < FB_H;
    assign wr_addr = {wr_y, wr_x};

    // Read and write share an edge, so a collision returns old data.
    always_ff @(posedge clock) begin
        if (wr_fire && wr_in_range) begin
            fb_mem[wr_addr] <= wr_data;
        end
        if (in_win) begin
            rd_data <= fb_mem[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p1 <= '0;
            wr_err <= 1'b0;
        end else begin
            p1.valid <= 1'b1;
            p1.active <= video_on_int;
            p1.in_win <= in_win;
            p1.hs <= hsync_int;
            p1.vs <= vsync_int;
            p1.fs <= (h_cnt == '0) && (v_cnt == '0);
            wr_err <= wr_fire & ~wr_in_range;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !p1.valid) begin
            rgb <= '0;
            h_sync <= ~SP;
            v_sync <= ~SP;
            video_on <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync <= p1.hs ? SP : ~SP;
            v_sync <= p1.vs ? SP : ~SP;
            video_on <= p1.active;
            frame_start <= p1.fs;
            if (!p1.active) begin
                rgb <= '0;
            end else if (p1.in_win) begin
                rgb <= rd_data;
            end else begin
                rgb <= BORDER_PIX;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_engine.sv
// Randomised bench for vga_fb_engine with a raster-level
// reference model; two instances cover both write policies.
module tb_vga_fb_engine;

    localparam int HA = 40;
    localparam int HFP = 4;
    localparam int HS = 6;
    localparam int HBP = 6;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VA = 30;
    localparam int VFP = 2;
    localparam int VS = 2;
    localparam int VBP = 3;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int FBW = 16;
    localparam int FBH = 12;
    localparam int SH = 1;
    localparam int BRD = 2;

    typedef struct {
        logic [2:0] rgb;
        logic       ok;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [2:0] wr_data = '0;
    logic       wr_ready_o [2];
    logic       wr_err_o [2];
    logic       hs_o [2];
    logic       vs_o [2];
    logic       vo_o [2];
    logic       fs_o [2];
    logic [2:0] rgb_o [2];

    always #5 clk = ~clk;

    vga_fb_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_W(3), .FB_XW(4), .FB_H(FBH), .SCALE_SHIFT(SH),
        .BORDER(BRD), .SYNC_POL(0), .WR_BLANK_ONLY(0)
    ) u_dut_a (
        .clock(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready_o[0]),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_err(wr_err_o[0]), .rgb(rgb_o[0]),
        .h_sync(hs_o[0]), .v_sync(vs_o[0]),
        .video_on(vo_o[0]), .frame_start(fs_o[0])
    );

    vga_fb_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_W(3), .FB_XW(4), .FB_H(FBH), .SCALE_SHIFT(SH),
        .BORDER(BRD), .SYNC_POL(0), .WR_BLANK_ONLY(1)
    ) u_dut_b (
        .clock(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready_o[1]),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_err(wr_err_o[1]), .rgb(rgb_o[1]),
        .h_sync(hs_o[1]), .v_sync(vs_o[1]),
        .video_on(vo_o[1]), .frame_start(fs_o[1])
    );

    exp_t       e_mid [2];
    exp_t       e_out [2];
    logic       err_exp [2];
    logic [2:0] mem [2][FBH][FBW];
    bit         known [2][FBH][FBW];
    int         t = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    bit         run_chk = 0;

    function automatic exp_t rst_exp();
        exp_t e;
        e.rgb = 3'd0;
        e.ok = 1'b1;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.vo = 1'b0;
        e.fs = 1'b0;
        return e;
    endfunction

    function automatic bit active_at(int tc);
        int h;
        int v;
        h = tc % HT;
        v = (tc / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic exp_ready(int d);
        return !reset && (d == 0 || !active_at(t));
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s t=%0d got=%0h want=%0h",
                     name, t, got, want);
        end
    endtask

    // Reference: pixel of raster position t appears two cycles later.
    initial forever begin
        int h;
        int v;
        int fx;
        int fy;
        bit act;
        bit inw;
        bit acc;
        @(posedge clk);
        if (reset) begin
            t = 0;
            for (int d = 0; d < 2; d++) begin
                e_out[d] = rst_exp();
                e_mid[d] = rst_exp();
                err_exp[d] = 1'b0;
            end
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            act = (h < HA) && (v < VA);
            fx = h >> SH;
            fy = v >> SH;
            inw = (fx < FBW) && (fy < FBH);
            for (int d = 0; d < 2; d++) begin
                e_out[d] = e_mid[d];
                e_mid[d].vo = act;
                e_mid[d].hs = !(h >= HA + HFP && h < HA + HFP + HS);
                e_mid[d].vs = !(v >= VA + VFP && v < VA + VFP + VS);
                e_mid[d].fs = (h == 0) && (v == 0);
                e_mid[d].ok = 1'b1;
                if (!act) begin
                    e_mid[d].rgb = 3'd0;
                end else if (!inw) begin
                    e_mid[d].rgb = 3'(BRD);
                end else begin
                    e_mid[d].rgb = mem[d][fy][fx];
                    e_mid[d].ok = known[d][fy][fx];
                end
                acc = wr_valid && (d == 0 || !act);
                err_exp[d] = acc && (int'(wr_y) >= FBH);
                if (acc && int'(wr_y) < FBH) begin
                    mem[d][wr_y][wr_x] = wr_data;
                    known[d][wr_y][wr_x] = 1'b1;
                end
            end
            t++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (run_chk) begin
            for (int d = 0; d < 2; d++) begin
                if (e_out[d].ok) begin
                    chk($sformatf("rgb%0d", d), 32'(rgb_o[d]),
                        32'(e_out[d].rgb));
                end
                chk($sformatf("h_sync%0d", d), 32'(hs_o[d]),
                    32'(e_out[d].hs));
                chk($sformatf("v_sync%0d", d), 32'(vs_o[d]),
                    32'(e_out[d].vs));
                chk($sformatf("video_on%0d", d), 32'(vo_o[d]),
                    32'(e_out[d].vo));
                chk($sformatf("frame_start%0d", d), 32'(fs_o[d]),
                    32'(e_out[d].fs));
                chk($sformatf("wr_err%0d", d), 32'(wr_err_o[d]),
                    32'(err_exp[d]));
                chk($sformatf("wr_ready%0d", d), 32'(wr_ready_o[d]),
                    32'(exp_ready(d)));
            end
        end
    end

    task automatic wait_cnt(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((t % FRAME) != v * HT + h && n < 3 * FRAME);
        if (n >= 3 * FRAME) chk("wait_cnt_timeout", 0, 1);
    endtask

    task automatic wait_out(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(t >= 2 && ((t - 2) % FRAME) == v * HT + h)
                   && n < 3 * FRAME);
        if (n >= 3 * FRAME) chk("wait_out_timeout", 0, 1);
    endtask

    // Caller is at posedge+2; holds the write until the blank-only copy takes it.
    task automatic write_px(input int x, input int y, input int data);
        int n;
        wr_x = 4'(x);
        wr_y = 4'(y);
        wr_data = 3'(data);
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready_o[1] && n < 3 * FRAME) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 3 * FRAME) chk("write_timeout", 0, 1);
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
    endtask

    task automatic check_first_frame_start();
        int n;
        n = 0;
        while (!fs_o[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_cycle", 32'(t), 32'd2);
    endtask

    initial begin
        int n;
        int t0;
        repeat (4) @(posedge clk);
        run_chk = 1;
        #2 reset = 1'b0;
        check_first_frame_start();

        n = 0;
        while (hs_o[0] && n < 200) begin @(negedge clk); n++; end
        t0 = t;
        chk("hsync_start", 32'(t0), 32'(HA + HFP + 2));
        n = 0;
        while (!hs_o[0] && n < 200) begin @(negedge clk); n++; end
        chk("hsync_width", 32'(n), 32'(HS));
        n = 0;
        while (hs_o[0] && n < 200) begin @(negedge clk); n++; end
        chk("hsync_period", 32'(t - t0), 32'(HT));

        n = 0;
        while (vs_o[0] && n < 3000) begin @(negedge clk); n++; end
        chk("vsync_start", 32'(t), 32'((VA + VFP) * HT + 2));
        n = 0;
        while (!vs_o[0] && n < 3000) begin @(negedge clk); n++; end
        chk("vsync_width", 32'(n), 32'(VS * HT));

        @(posedge clk);
        #2;
        for (int y = 0; y < FBH; y++) begin
            for (int x = 0; x < FBW; x++) begin
                write_px(x, y, int'($urandom_range(0, 7)));
            end
        end

        write_px(3, 2, 5);
        wait_out(6, 4);
        chk("dot_6_4_a", 32'(rgb_o[0]), 32'd5);
        chk("dot_6_4_b", 32'(rgb_o[1]), 32'd5);
        wait_out(7, 5);
        chk("dot_7_5_a", 32'(rgb_o[0]), 32'd5);
        chk("dot_7_5_b", 32'(rgb_o[1]), 32'd5);

        wait_out(35, 3);
        chk("border_h", 32'(rgb_o[0]), 32'(BRD));
        wait_out(45, 3);
        chk("blank_rgb", 32'(rgb_o[0]), 32'd0);
        chk("blank_video_on", 32'(vo_o[0]), 32'd0);
        wait_out(5, 26);
        chk("border_v", 32'(rgb_o[1]), 32'(BRD));

        wait_cnt(10, 1);
        wr_x = 4'd1;
        wr_y = 4'd0;
        wr_data = 3'd6;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready_o[1] && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("wbo_stall", 32'(n), 32'(HA - 10));
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
        wait_out(2, 0);
        chk("wbo_dot_a", 32'(rgb_o[0]), 32'd6);
        chk("wbo_dot_b", 32'(rgb_o[1]), 32'd6);

        wait_cnt(45, 2);
        wr_x = 4'd0;
        wr_y = 4'd14;
        wr_data = 3'd7;
        wr_valid = 1'b1;
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_err_pulse_a", 32'(wr_err_o[0]), 32'd1);
        chk("wr_err_pulse_b", 32'(wr_err_o[1]), 32'd1);
        @(negedge clk);
        chk("wr_err_clear", 32'(wr_err_o[0]), 32'd0);

        wait_cnt(30, 20);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_video_on", 32'(vo_o[0]), 32'd0);
        chk("rst_h_sync", 32'(hs_o[0]), 32'd1);
        chk("rst_rgb", 32'(rgb_o[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check_first_frame_start();
        wait_out(6, 4);
        chk("ram_kept_a", 32'(rgb_o[0]), 32'd5);
        chk("ram_kept_b", 32'(rgb_o[1]), 32'd5);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            reset = (i >= 2500 && i < 2502);
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 4'($urandom);
            wr_y = 4'($urandom);
            wr_data = 3'($urandom);
        end
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        run_chk = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
